// File: rtl/alu_md.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define ALU_MD_EARLY_OUT_EN to finish trivial cases (x/0, MIN/-1, multiply by zero) in one cycle.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic a_is_signed(input logic [2:0] o);
        return (o == 3'b001) || (o == 3'b010) || (o == 3'b100) || (o == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] o);
        return (o == 3'b001) || (o == 3'b100) || (o == 3'b110);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (ALL_ZERO - v) : v;
    endfunction

    function automatic logic is_ovf(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        return ((o == 3'b100) || (o == 3'b110)) && (a == MOST_NEG) && (b == ALL_ONES);
    endfunction

    // p holds {high,low} of the magnitude product, or {remainder,quotient} for divides.
    function automatic logic [WIDTH-1:0] final_res(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2*WIDTH-1:0] p);
        logic sa;
        logic sb;
        logic [2*WIDTH-1:0] pm;
        logic [WIDTH-1:0] res;
        sa  = a_is_signed(o) && a[WIDTH-1];
        sb  = b_is_signed(o) && b[WIDTH-1];
        pm  = (sa ^ sb) ? ({(2*WIDTH){1'b0}} - p) : p;
        res = ALL_ZERO;
        case (o)
            3'b000:                 res = pm[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res = pm[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (b == ALL_ZERO) res = ALL_ONES;
                else if (is_ovf(o, a, b)) res = a;
                else res = ((o == 3'b100) && (sa ^ sb)) ? (ALL_ZERO - p[WIDTH-1:0]) : p[WIDTH-1:0];
            end
            3'b110, 3'b111: begin
                if (b == ALL_ZERO) res = a;
                else if (is_ovf(o, a, b)) res = ALL_ZERO;
                else res = ((o == 3'b110) && sa) ? (ALL_ZERO - p[2*WIDTH-1:WIDTH])
                                                : p[2*WIDTH-1:WIDTH];
            end
            default:                res = ALL_ZERO;
        endcase
        return res;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   c_r;
    logic               zero_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] init_s;
    logic [WIDTH-1:0]   res_s;
    logic [WIDTH-1:0]   early_res_s;
    logic               early_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign C         = c_r;
    assign Zero      = zero_r;

    // One multiply or divide iteration on the latched operand magnitudes.
    always_comb begin
        addend_s    = ALL_ZERO;
        mul_sum_s   = {(WIDTH+1){1'b0}};
        div_shift_s = {(WIDTH+1){1'b0}};
        div_diff_s  = {(WIDTH+1){1'b0}};
        step_s      = prod_r;
        if (op_r[2]) begin
            addend_s    = mag(b_r, b_is_signed(op_r));
            div_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
            div_diff_s  = div_shift_s - {1'b0, addend_s};
            if (div_diff_s[WIDTH]) begin
                step_s = {div_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
            end else begin
                step_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            addend_s  = mag(a_r, a_is_signed(op_r));
            mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                      + (prod_r[0] ? {1'b0, addend_s} : {(WIDTH+1){1'b0}});
            step_s    = {mul_sum_s, prod_r[WIDTH-1:1]};
        end
    end

    // Accept-time values: initial iteration register and the sign-corrected final result.
    always_comb begin
        if (op[2]) begin
            init_s = {ALL_ZERO, mag(A, a_is_signed(op))};
        end else begin
            init_s = {ALL_ZERO, mag(B, b_is_signed(op))};
        end
        res_s       = final_res(op_r, a_r, b_r, step_s);
        early_res_s = final_res(op, A, B, {(2*WIDTH){1'b0}});
    end

`ifdef ALU_MD_EARLY_OUT_EN
    assign early_s = op[2] ? ((B == ALL_ZERO) || is_ovf(op, A, B))
                           : ((A == ALL_ZERO) || (B == ALL_ZERO));
`else
    assign early_s = 1'b0;
`endif

    // Control FSM with latched operands and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= 3'b000;
            a_r         <= ALL_ZERO;
            b_r         <= ALL_ZERO;
            prod_r      <= {(2*WIDTH){1'b0}};
            c_r         <= ALL_ZERO;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        op_r       <= op;
                        a_r        <= A;
                        b_r        <= B;
                        cnt_r      <= {CNT_W{1'b0}};
                        prod_r     <= init_s;
                        in_ready_r <= 1'b0;
                        if (early_s) begin
                            state_r     <= DONE;
                            c_r         <= early_res_s;
                            zero_r      <= (early_res_s == ALL_ZERO);
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod_r <= step_s;
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= DONE;
                        c_r         <= res_s;
                        zero_r      <= (res_s == ALL_ZERO);
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        zero_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: driver queues expected results, a negedge monitor checks them.
module tb_alu_md;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] C;
    logic         Zero;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen = 1'b0;
    exp_t sb[$];

    alu_md #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C), .Zero(Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: first negedge of each out_valid burst pops and checks one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", W'(out_valid), W'(0));
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_C"}, C, e.c);
                    chk({e.name, "_Zero"}, W'(Zero), W'(e.z));
                    chk({e.name, "_lat"}, W'(cyc - e.acc + 1), W'(e.lat));
                end
            end
            if (!out_valid) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] ec, input logic ez,
                         input bit early, input string nm);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, W'(in_ready), W'(1));
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.c = ec;
            e.z = ez;
`ifdef ALU_MD_EARLY_OUT_EN
            e.lat = early ? 1 : W + 1;
`else
            e.lat = W + 1;
`endif
            e.acc  = cyc;
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(in_ready && sb.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({nm, "_idle_timeout"}, W'(sb.size()), W'(0));
    endtask

    initial begin
        int n;
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_C", C, '0);
        chk("rst_Zero", W'(Zero), W'(0));
        @(negedge clk);
        rstn = 1'b1;

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 1'b0, 0, "mul_7_m3");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b0, 0, "mulhu_ff");
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b1, 0, "mulh_m1");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 1'b0, 0, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 1'b0, 0, "rem_m7_2");
        issue(3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1, "divu_by0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0, 1, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b1, 1, "rem_ovf");
        issue(3'b111, 32'd5, 32'd0, 1, 32'd5, 1'b0, 1, "remu_by0");
        issue(3'b100, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1, "div_m5_by0");
        issue(3'b110, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 1'b0, 1, "rem_m5_by0");
        issue(3'b000, 32'd0, 32'd12345, 1, 32'd0, 1'b1, 1, "mul_zero");
        issue(3'b010, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 1'b0, 0, "mulhsu_m2_3");
        issue(3'b101, 32'd100, 32'd7, 1, 32'd14, 1'b0, 0, "divu_100_7");
        issue(3'b111, 32'd100, 32'd7, 1, 32'd2, 1'b0, 0, "remu_100_7");
        issue(3'b100, 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 1'b0, 0, "div_7_m2");
        issue(3'b110, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 1'b0, 0, "rem_7_m2");
        issue(3'b000, 32'h1234_5678, 32'h10, 1, 32'h2345_6780, 1'b0, 0, "mul_shift");
        issue(3'b011, 32'h8000_0000, 32'd4, 1, 32'd2, 1'b0, 0, "mulhu_hi");
        wait_idle("vectors");

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 1, 32'd15, 1'b0, 0, "stall_mul");
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_wait", W'(out_valid), W'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", W'(out_valid), W'(1));
            chk("stall_C", C, 32'd15);
            chk("stall_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", W'(out_valid), W'(0));
        chk("release_in_ready", W'(in_ready), W'(1));

        // flush competing with in_valid in IDLE: nothing accepted.
        op = 3'b000; A = 32'd2; B = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", W'(in_ready), W'(1));

        // flush mid-CALC discards the operation.
        issue(3'b101, 32'd100, 32'd7, 0, '0, 1'b0, 0, "flushed");
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_in_ready", W'(in_ready), W'(1));

        // Asynchronous reset mid-CALC abandons the operation.
        issue(3'b000, 32'd9, 32'd9, 0, '0, 1'b0, 0, "reset_op");
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_C", C, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        repeat (40) @(negedge clk);
        chk("post_rst_no_valid", W'(out_valid), W'(0));

        issue(3'b000, 32'd6, 32'd7, 1, 32'd42, 1'b0, 0, "mul_after_rst");
        wait_idle("final");
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (even, >= 8).
REQ-002 Parameter CNT_W, default 6, counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 flush  input  1  pipeline kill, synchronous; aborts any operation.
REQ-006 in_valid  input  1  operands and op present.
REQ-007 in_ready  output  1  unit can accept; high only in IDLE.
REQ-008 op  input  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-009 A, B  input  WIDTH each  rs1 and rs2 operands.
REQ-010 out_valid  output  1  result C valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 C  output  WIDTH  result, registered.
REQ-013 Zero  output  1  high when C == 0, qualified only with out_valid.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 IDLE->CALC on in_valid && in_ready && !flush; op, A and B SHALL be latched that cycle.
REQ-016 In CALC the unit SHALL do one iteration per cycle: shift-add for multiply, restoring for divide, on operand magnitudes with the sign fixed at the end.
REQ-017 CALC SHALL last exactly WIDTH cycles, then go to DONE; accept-to-out_valid latency is WIDTH+1 cycles.
REQ-018 DONE SHALL hold out_valid=1 and C stable until out_ready=1, then go to IDLE.
REQ-019 in_ready SHALL be low in CALC and DONE; a new op SHALL NOT be accepted in the same cycle a result is consumed.
REQ-020 mul SHALL give the low WIDTH bits of the product; mulh, mulhsu and mulhu SHALL give the high WIDTH bits with signed×signed, signed×unsigned and unsigned×unsigned operands.
REQ-021 Divide by zero: div and divu SHALL give all ones, rem and remu SHALL give A.
REQ-022 Signed overflow (A = most negative, B = -1): div SHALL give A and rem SHALL give 0.
REQ-023 Otherwise quotients SHALL round toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 flush SHALL send any state to IDLE next cycle with out_valid=0, discarding the result.
REQ-025 flush with in_valid in IDLE: flush SHALL win and nothing is accepted.
REQ-026 Iteration counter SHALL be CNT_W bits, cleared on accept, with no wrap within an operation.

Reset
REQ-027 rstn low SHALL force IDLE immediately: in_ready=1, out_valid=0, C=0, counter=0, latched operands 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abandon the operation with no output pulse after release.
REQ-029 The first accept SHALL be possible on the first rising edge with rstn high.

Configuration
REQ-030 Macro ALU_MD_EARLY_OUT_EN SHALL control early-out.
REQ-031 With ALU_MD_EARLY_OUT_EN defined, divide by zero, signed overflow, and multiply with A==0 or B==0 SHALL skip CALC: accept goes to DONE, latency 1 cycle.
REQ-032 With ALU_MD_EARLY_OUT_EN undefined, every op SHALL take WIDTH+1 cycles; results SHALL be bit-identical in both builds.

Verification
REQ-033 WIDTH=32, mul A=7 B=-3 -> out_valid after 33 cycles, C=0xFFFFFFEB, Zero=0.
REQ-034 mulhu A=B=0xFFFFFFFF -> C=0xFFFFFFFE; mulh same operands -> C=0x00000000, Zero=1.
REQ-035 div A=-7 B=2 -> C=0xFFFFFFFD; rem same operands -> C=0xFFFFFFFF.
REQ-036 divu A=5 B=0 -> C=0xFFFFFFFF; div A=0x80000000 B=-1 -> C=0x80000000; both 1-cycle with the macro, 33 cycles without.
REQ-037 Hold out_ready=0 for 10 cycles in DONE -> C and out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-038 flush at CALC cycle 5, then rstn pulse low at CALC cycle 10 of a later op -> no out_valid for either op, in_ready=1 next cycle.
